mc_ctrl: RTL and testbench

Multi-cycle control unit that sequences the CPU datapath over several clocks per instruction, instead of the single-cycle combinational decode.
- Fetches each instruction over a shared instruction/data memory port using a ready handshake.
- Decodes the latched op/func fields and steps through EXEC/MEM/WB.
- Drives the datapath enables: PC, IR, register file, ALU source and function, and memory.
- Sits between the memory port and the existing datapath registers.

---
 rtl/mc_ctrl_if.sv | 11 +
 rtl/mc_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Shared instruction/data memory port between the multi-cycle controller and memory.
// The controller raises mem_req and holds it until memory answers with mem_ready.
interface mc_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, mem_we, iord, input mem_ready);
    modport slave  (input mem_req, mem_we, iord, output mem_ready);
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencing over one shared memory port.
// Optional macro MC_CTRL_PERF_EN adds instr_cnt/stall_cnt performance counters.
module mc_ctrl #(
    parameter int OP_W  = 6,
    parameter int FN_W  = 4,
    parameter int ALU_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [OP_W-1:0]  op,
    input  logic [FN_W-1:0]  func,
    mc_ctrl_if.master        mem,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src_jump,
    output logic [ALU_W-1:0] alu_func,
    output logic             alu_src_imm,
    output logic             reg_we,
    output logic             mem_to_reg,
    output logic             busy,
    output logic             illegal
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0]      instr_cnt,
    output logic [31:0]      stall_cnt
`endif
);

    localparam logic [OP_W-1:0] OP_R   = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_ORI = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_LW  = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW  = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_J   = OP_W'(6'b000010);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM_RD, S_MEM_WR, S_WB, S_JUMP, S_TRAP
    } state_t;

    state_t state_reg, state_next;
    logic   mem_req_c, mem_we_c, iord_c;
    state_t end_next;

    // Only the low function bits select the ALU operation for R-type.
    wire unused_fn = ^func;

    assign mem.mem_req = mem_req_c;
    assign mem.mem_we  = mem_we_c;
    assign mem.iord    = iord_c;

    // run is looked at only when an instruction finishes.
    assign end_next = run ? S_FETCH : S_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        iord_c      = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src_jump = 1'b0;
        alu_func    = '0;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        mem_to_reg  = 1'b0;
        busy        = 1'b0;
        illegal     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                busy      = 1'b1;
                mem_req_c = 1'b1;
                if (mem.mem_ready) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                busy = 1'b1;
                case (op)
                    OP_R, OP_ORI, OP_LW, OP_SW: state_next = S_EXEC;
                    OP_J:                       state_next = S_JUMP;
                    default:                    state_next = S_TRAP;
                endcase
            end
            S_EXEC: begin
                busy = 1'b1;
                case (op)
                    OP_R: begin
                        alu_func   = ALU_W'(func[2:0]);
                        state_next = S_WB;
                    end
                    OP_ORI: begin
                        alu_func    = ALU_W'(3'b001);
                        alu_src_imm = 1'b1;
                        state_next  = S_WB;
                    end
                    OP_LW: begin
                        alu_func    = ALU_W'(3'b010);
                        alu_src_imm = 1'b1;
                        state_next  = S_MEM_RD;
                    end
                    OP_SW: begin
                        alu_func    = ALU_W'(3'b010);
                        alu_src_imm = 1'b1;
                        state_next  = S_MEM_WR;
                    end
                    default: state_next = S_TRAP;
                endcase
            end
            S_MEM_RD: begin
                busy      = 1'b1;
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                if (mem.mem_ready) state_next = S_WB;
            end
            S_MEM_WR: begin
                busy      = 1'b1;
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                iord_c    = 1'b1;
                if (mem.mem_ready) state_next = end_next;
            end
            S_WB: begin
                busy       = 1'b1;
                reg_we     = 1'b1;
                mem_to_reg = (op == OP_LW);
                state_next = end_next;
            end
            S_JUMP: begin
                busy        = 1'b1;
                pc_we       = 1'b1;
                pc_src_jump = 1'b1;
                state_next  = end_next;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
    end

`ifdef MC_CTRL_PERF_EN
    logic instr_done, mem_stall;

    assign instr_done = (state_reg == S_WB) || (state_reg == S_JUMP) ||
                        ((state_reg == S_MEM_WR) && mem.mem_ready);
    assign mem_stall  = ((state_reg == S_FETCH) || (state_reg == S_MEM_RD) ||
                         (state_reg == S_MEM_WR)) && !mem.mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (instr_done) instr_cnt <= instr_cnt + 32'd1;
            if (mem_stall)  stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Cycle-by-cycle check of mc_ctrl against a per-instruction schedule built from the opcode rules.
// Each scheduled cycle carries the inputs to drive and the complete output word required.
module tb_mc_ctrl;
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_J   = 6'b000010;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [5:0] op = '0;
    logic [3:0] func = '0;
    logic       ir_we, pc_we, pc_src_jump, alu_src_imm, reg_we, mem_to_reg, busy, illegal;
    logic [2:0] alu_func;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] instr_cnt, stall_cnt;
`endif

    mc_ctrl_if mif();

    mc_ctrl #(.OP_W(6), .FN_W(4), .ALU_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .op(op), .func(func), .mem(mif),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src_jump(pc_src_jump), .alu_func(alu_func),
        .alu_src_imm(alu_src_imm), .reg_we(reg_we), .mem_to_reg(mem_to_reg),
        .busy(busy), .illegal(illegal)
`ifdef MC_CTRL_PERF_EN
        , .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    wire [13:0] obs = {mif.mem_req, mif.mem_we, mif.iord, ir_we, pc_we, pc_src_jump,
                       alu_func, alu_src_imm, reg_we, mem_to_reg, busy, illegal};

    typedef struct {
        logic       rdy;
        logic       rn;
        logic [5:0] o;
        logic [3:0] f;
        logic [13:0] exp;
    } cyc_t;

    cyc_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_instr = 0;
    int   exp_stall = 0;
    logic in_idle = 1'b1;

    function automatic logic [13:0] mk(input logic req, we, ior, irw, pcw, pcj,
                                       input logic [2:0] af, input logic imm, rw, m2r, bsy, ill);
        return {req, we, ior, irw, pcw, pcj, af, imm, rw, m2r, bsy, ill};
    endfunction

    function automatic void push(input logic rdy, rn, input logic [5:0] o, input logic [3:0] f,
                                 input logic [13:0] exp);
        cyc_t c;
        c.rdy = rdy; c.rn = rn; c.o = o; c.f = f; c.exp = exp;
        q.push_back(c);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Fetch with fw wait cycles; op/func are junk until the IR has loaded.
    task automatic add_fetch(input int fw);
        if (in_idle) push(rb(), 1'b1, 6'($urandom), 4'($urandom), '0);
        for (int w = 0; w <= fw; w++) begin
            push(w == fw, rb(), 6'($urandom), 4'($urandom),
                 mk(1, 0, 0, w == fw, w == fw, 0, 3'd0, 0, 0, 0, 1, 0));
            if (w < fw) exp_stall++;
        end
    endtask

    task automatic add_instr(input logic [5:0] o, input logic [3:0] f, input int fw, input int mw,
                             input logic run_next);
        logic [2:0] af;
        add_fetch(fw);
        push(rb(), rb(), o, f, mk(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1, 0));
        if (o == OP_J) begin
            push(rb(), run_next, o, f, mk(0, 0, 0, 0, 1, 1, 3'd0, 0, 0, 0, 1, 0));
        end else begin
            af = (o == OP_R) ? f[2:0] : (o == OP_ORI) ? 3'b001 : 3'b010;
            push(rb(), rb(), o, f, mk(0, 0, 0, 0, 0, 0, af, o != OP_R, 0, 0, 1, 0));
            if (o == OP_LW) begin
                for (int w = 0; w <= mw; w++) begin
                    push(w == mw, rb(), o, f, mk(1, 0, 1, 0, 0, 0, 3'd0, 0, 0, 0, 1, 0));
                    if (w < mw) exp_stall++;
                end
            end
            if (o == OP_SW) begin
                for (int w = 0; w <= mw; w++) begin
                    push(w == mw, (w == mw) ? run_next : rb(), o, f,
                         mk(1, 1, 1, 0, 0, 0, 3'd0, 0, 0, 0, 1, 0));
                    if (w < mw) exp_stall++;
                end
            end else begin
                push(rb(), run_next, o, f, mk(0, 0, 0, 0, 0, 0, 3'd0, 0, 1, o == OP_LW, 1, 0));
            end
        end
        exp_instr++;
        if (!run_next) begin
            for (int k = 0; k <= int'($urandom_range(0, 2)); k++)
                push(rb(), 1'b0, 6'($urandom), 4'($urandom), '0);
        end
        in_idle = !run_next;
        $display("instr op=%b func=%b fetch_wait=%0d mem_wait=%0d run_next=%0d",
                 o, f, fw, mw, run_next);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mif.mem_ready = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if (obs !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_state: outputs %b required %b", obs, 14'd0);
        end
        rst_n = 1'b1;
        in_idle = 1'b1;
        push(1'b0, 1'b1, 6'd0, 4'd0, '0);
        for (int w = 0; w < 3; w++)
            push(1'b0, rb(), 6'($urandom), 4'($urandom), mk(1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1, 0));
        for (int n = 0; q.size() > 0; n++) begin
            cyc_t c = q.pop_front();
            @(negedge clk);
            mif.mem_ready = c.rdy; run = c.rn; op = c.o; func = c.f;
            #1;
            vectors++;
            if (obs !== c.exp) begin
                miscompares++;
                $display("FAIL fetch_hold cycle %0d: outputs %b required %b", n, obs, c.exp);
            end
        end
        // Reset lands between clock edges while the fetch request is outstanding.
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_mid_fetch: outputs %b required %b", obs, 14'd0);
        end
        @(negedge clk);
        run = 1'b0;
        rst_n = 1'b1;
        exp_instr = 0;
        exp_stall = 0;
        in_idle = 1'b1;
        $display("reset checks done");
    endtask

    task automatic test_directed();
        add_instr(OP_R, 4'b0010, 0, 0, 1'b1);
        add_instr(OP_LW, 4'($urandom), 0, 3, 1'b1);
        add_instr(OP_SW, 4'($urandom), 0, 0, 1'b1);
        add_instr(OP_J, 4'($urandom), 0, 0, 1'b0);
        for (int n = 0; q.size() > 0; n++) begin
            cyc_t c = q.pop_front();
            @(negedge clk);
            mif.mem_ready = c.rdy; run = c.rn; op = c.o; func = c.f;
            #1;
            vectors++;
            if (obs !== c.exp) begin
                miscompares++;
                $display("FAIL directed cycle %0d op=%b: outputs %b required %b", n, c.o, obs, c.exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [5];
        ops = '{OP_R, OP_ORI, OP_LW, OP_SW, OP_J};
        for (int i = 0; i < 14; i++) begin
            add_instr(ops[$urandom_range(0, 4)], 4'($urandom), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)), (i % 4 == 3) ? 1'b0 : rb());
        end
        for (int n = 0; q.size() > 0; n++) begin
            cyc_t c = q.pop_front();
            @(negedge clk);
            mif.mem_ready = c.rdy; run = c.rn; op = c.o; func = c.f;
            #1;
            vectors++;
            if (obs !== c.exp) begin
                miscompares++;
                $display("FAIL back_to_back cycle %0d op=%b: outputs %b required %b", n, c.o, obs, c.exp);
            end
        end
    endtask

    task automatic test_trap();
        int fw;
        fw = int'($urandom_range(0, 2));
        add_fetch(fw);
        push(rb(), rb(), 6'b111111, 4'($urandom), mk(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1, 0));
        for (int k = 0; k < 20; k++)
            push(rb(), rb(), 6'b111111, 4'($urandom), mk(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 1));
        for (int n = 0; q.size() > 0; n++) begin
            cyc_t c = q.pop_front();
            @(negedge clk);
            mif.mem_ready = c.rdy; run = c.rn; op = c.o; func = c.f;
            #1;
            vectors++;
            if (obs !== c.exp) begin
                miscompares++;
                $display("FAIL trap cycle %0d: outputs %b required %b", n, obs, c.exp);
            end
        end
`ifdef MC_CTRL_PERF_EN
        vectors++;
        if (instr_cnt !== 32'(exp_instr)) begin
            miscompares++;
            $display("FAIL instr_cnt: got %0d required %0d", instr_cnt, exp_instr);
        end
        vectors++;
        if (stall_cnt !== 32'(exp_stall)) begin
            miscompares++;
            $display("FAIL stall_cnt: got %0d required %0d", stall_cnt, exp_stall);
        end
`endif
        run = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== 14'd0) begin
            miscompares++;
            $display("FAIL trap_reset: outputs %b required %b", obs, 14'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if (obs !== 14'd0) begin
            miscompares++;
            $display("FAIL idle_after_trap: outputs %b required %b", obs, 14'd0);
        end
        $display("trap checks done after %0d legal instructions", exp_instr);
    endtask

    initial begin
        mif.mem_ready = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_trap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
